ppc_gpr_file: RTL and testbench

Parametrised general-purpose register file for the pipelined PowerPC core. It replaces the fixed 2-read/2-write GPR array and the core's hand-built one-cycle-ago write history. It provides NRD synchronous read ports with built-in write-to-read bypass, so decode sees every write committed up to and including its request cycle. An optional scoreboard tracks registers with writes in flight (loads, update-form addressing) and flags reads of them for stall logic in the pipeline controller.

---
 rtl/ppc_pkg.sv | 11 +
 rtl/ppc_gpr_bypass.sv | 30 +++
 rtl/ppc_gpr_file.sv | 129 ++++++++++++
 tb/tb_ppc_gpr_file.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppc_pkg.sv
// Shared PowerPC core definitions: GPR geometry and the address/data types
// used by decode and writeback.
package ppc_pkg;

    localparam int unsigned PPC_XLEN = 64;
    localparam int unsigned PPC_NGPR = 32;

    typedef logic [$clog2(PPC_NGPR)-1:0] gpr_addr_t;
    typedef logic [PPC_XLEN-1:0]         gpr_data_t;

endpackage

// File: rtl/ppc_gpr_bypass.sv
// Write-to-read bypass for one read port: picks the highest-index enabled
// write port whose address matches the read address.
module ppc_gpr_bypass
    import ppc_pkg::*;
#(
    parameter int unsigned XLEN = PPC_XLEN,
    parameter int unsigned AW   = $clog2(PPC_NGPR),
    parameter int unsigned NWR  = 2
) (
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic                hit,
    output logic [XLEN-1:0]     data
);

    // Ascending scan so a later (higher-index) match overrides earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr)) begin
                hit  = 1'b1;
                data = wr_data[w*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/ppc_gpr_file.sv
// Parametrised GPR file: NRD registered read ports with same-cycle write
// bypass and NWR write ports (highest index wins on address conflicts).
// Optional busy-bit scoreboard enabled by defining GPR_SCOREBOARD_EN; without
// it rd_busy is tied to 0 and rsv_en/rsv_addr/flush are ignored.
module ppc_gpr_file
    import ppc_pkg::*;
#(
    parameter int unsigned XLEN  = PPC_XLEN,
    parameter int unsigned NREGS = PPC_NGPR,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                flush
);

    logic [XLEN-1:0]     mem_q [NREGS];
    logic [NRD*XLEN-1:0] rd_data_q;
    logic                byp_hit  [NRD];
    logic [XLEN-1:0]     byp_data [NRD];
    logic [XLEN-1:0]     rd_next  [NRD];

    // Array update; ascending loop lets the highest-index port win a conflict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w]) begin
                    mem_q[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_bypass
        ppc_gpr_bypass #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_bypass (
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_addr (rd_addr[p*AW +: AW]),
            .hit     (byp_hit[p]),
            .data    (byp_data[p])
        );
    end

    // Value the array will hold after this edge: forwarded write or stored entry.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_next[p] = byp_hit[p] ? byp_data[p] : mem_q[rd_addr[p*AW +: AW]];
        end
    end

    // Read data registers; a port without a request holds its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            for (int p = 0; p < NRD; p++) begin
                if (rd_en[p]) begin
                    rd_data_q[p*XLEN +: XLEN] <= rd_next[p];
                end
            end
        end
    end

    assign rd_data = rd_data_q;

`ifdef GPR_SCOREBOARD_EN
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NRD-1:0]   rd_busy_q;

    // Busy next state: writes clear, a reservation re-sets (younger owner),
    // flush wipes everything including a same-cycle reservation.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
                busy_d[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (flush) begin
            busy_d = '0;
        end else if (rsv_en) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // Busy bits and per-port busy flags, sampled after this edge's updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q    <= '0;
            rd_busy_q <= '0;
        end else begin
            busy_q <= busy_d;
            for (int p = 0; p < NRD; p++) begin
                if (rd_en[p]) begin
                    rd_busy_q[p] <= busy_d[rd_addr[p*AW +: AW]];
                end
            end
        end
    end

    assign rd_busy = rd_busy_q;
`else
    logic unused_sb;
    assign unused_sb = ^{rsv_en, rsv_addr, flush};
    assign rd_busy   = '0;
`endif

endmodule

// File: tb/tb_ppc_gpr_file.sv
// Self-checking bench for ppc_gpr_file: directed scenarios plus randomized
// traffic against an array/bit-vector reference model.
module tb_ppc_gpr_file;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;
`ifdef GPR_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                flush;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [XLEN-1:0] m_mem  [NREGS];
    bit              m_busy [NREGS];
    logic [XLEN-1:0] e_data [NRD];
    logic            e_busy [NRD];

    always #5 clk = ~clk;

    ppc_gpr_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush)
    );

    task automatic idle();
        rst_n    = 1'b1;
        rd_en    = '0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        flush    = 1'b0;
    endtask

    task automatic set_wr(input int w, input int a, input logic [XLEN-1:0] d);
        wr_en[w]                  = 1'b1;
        wr_addr[w*AW +: AW]       = AW'(a);
        wr_data[w*XLEN +: XLEN]   = d;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_en[p]            = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    // One clock: model consumes the current inputs at the edge, then the
    // caller sees DUT outputs 1 time unit later.
    task automatic step();
        int a;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
            for (int p = 0; p < NRD; p++) begin
                e_data[p] = '0;
                e_busy[p] = 1'b0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_en[w]) begin
                    a = int'(wr_addr[w*AW +: AW]);
                    m_mem[a]  = wr_data[w*XLEN +: XLEN];
                    m_busy[a] = 1'b0;
                end
            end
            if (flush) begin
                for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
            end else if (rsv_en) begin
                m_busy[int'(rsv_addr)] = 1'b1;
            end
            for (int p = 0; p < NRD; p++) begin
                if (rd_en[p]) begin
                    a = int'(rd_addr[p*AW +: AW]);
                    e_data[p] = m_mem[a];
                    e_busy[p] = SB ? m_busy[a] : 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        step();
        for (int p = 0; p < NRD; p++) begin
            n_checks++;
            if (rd_data[p*XLEN +: XLEN] !== '0 || rd_busy[p] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_out p%0d: got data=%h busy=%b, want 0/0", p,
                         rd_data[p*XLEN +: XLEN], rd_busy[p]);
            end
        end
        idle();
        set_wr(0, 5, 64'h1234);
        rsv_en = 1'b1; rsv_addr = 5'd5;
        step();
        idle();
        rst_n = 1'b0;
        set_wr(1, 6, 64'hAA);   // ignored during reset
        rsv_en = 1'b1; rsv_addr = 5'd6;
        step();
        idle();
        set_rd(0, 5);
        set_rd(1, 6);
        step();
        n_checks++;
        if (rd_data[0 +: XLEN] !== 64'h0 || rd_busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_r5: got data=%h busy=%b, want 0/0", rd_data[0 +: XLEN], rd_busy[0]);
        end
        n_checks++;
        if (rd_data[XLEN +: XLEN] !== 64'h0 || rd_busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ignore_wr: got data=%h busy=%b, want 0/0",
                     rd_data[XLEN +: XLEN], rd_busy[1]);
        end
    endtask

    task automatic test_bypass();
        idle();
        set_wr(0, 7, 64'hDEAD_BEEF);
        set_rd(0, 7);
        set_rd(1, 7);
        step();
        for (int p = 0; p < NRD; p++) begin
            n_checks++;
            if (rd_data[p*XLEN +: XLEN] !== 64'hDEAD_BEEF) begin
                n_fail++;
                $display("FAIL bypass p%0d: got %h, want deadbeef", p, rd_data[p*XLEN +: XLEN]);
            end
        end
    endtask

    task automatic test_conflict();
        idle();
        set_wr(0, 3, 64'h11);
        set_wr(1, 3, 64'h22);
        set_rd(1, 3);
        step();
        n_checks++;
        if (rd_data[XLEN +: XLEN] !== 64'h22) begin
            n_fail++;
            $display("FAIL conflict_bypass: got %h, want 22", rd_data[XLEN +: XLEN]);
        end
        idle();
        set_rd(0, 3);
        step();
        n_checks++;
        if (rd_data[0 +: XLEN] !== 64'h22) begin
            n_fail++;
            $display("FAIL conflict_stored: got %h, want 22", rd_data[0 +: XLEN]);
        end
    endtask

    task automatic test_hold();
        idle();
        set_wr(1, 4, 64'h55);
        step();
        idle();
        set_rd(0, 4);
        step();
        n_checks++;
        if (rd_data[0 +: XLEN] !== 64'h55) begin
            n_fail++;
            $display("FAIL hold_read: got %h, want 55", rd_data[0 +: XLEN]);
        end
        idle();
        set_wr(0, 4, 64'h66);
        step();
        idle();
        step();
        n_checks++;
        if (rd_data[0 +: XLEN] !== 64'h55) begin
            n_fail++;
            $display("FAIL hold_keep: got %h, want 55", rd_data[0 +: XLEN]);
        end
        set_rd(0, 4);
        step();
        n_checks++;
        if (rd_data[0 +: XLEN] !== 64'h66) begin
            n_fail++;
            $display("FAIL hold_reread: got %h, want 66", rd_data[0 +: XLEN]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd9;
        step();
        idle();
        set_rd(1, 9);
        step();
        n_checks++;
        if (rd_busy[1] !== SB) begin
            n_fail++;
            $display("FAIL sb_reserved: got busy=%b, want %b", rd_busy[1], SB);
        end
        idle();
        set_wr(0, 9, 64'h99);
        set_rd(1, 9);
        step();
        n_checks++;
        if (rd_data[XLEN +: XLEN] !== 64'h99 || rd_busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_clear: got data=%h busy=%b, want 99/0",
                     rd_data[XLEN +: XLEN], rd_busy[1]);
        end
        // Same-cycle write and reserve: reservation survives.
        idle();
        set_wr(1, 10, 64'hA0);
        rsv_en = 1'b1; rsv_addr = 5'd10;
        step();
        idle();
        set_rd(0, 10);
        step();
        n_checks++;
        if (rd_busy[0] !== SB || rd_data[0 +: XLEN] !== 64'hA0) begin
            n_fail++;
            $display("FAIL sb_set_wins: got data=%h busy=%b, want a0/%b",
                     rd_data[0 +: XLEN], rd_busy[0], SB);
        end
    endtask

    task automatic test_flush();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd2;
        step();
        idle();
        flush  = 1'b1;
        rsv_en = 1'b1; rsv_addr = 5'd2;
        step();
        idle();
        set_rd(0, 2);
        set_rd(1, 10);
        step();
        n_checks++;
        if (rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_priority: got busy=%b, want 00", rd_busy);
        end
    endtask

    task automatic test_random();
        idle();
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int w = 0; w < NWR; w++) begin
                wr_en[w] = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    set_wr(w, int'($urandom_range(0, 7)), {$urandom, $urandom});
                end
            end
            for (int p = 0; p < NRD; p++) begin
                rd_en[p]            = ($urandom_range(0, 3) != 0);
                rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
            end
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = AW'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 15) == 0);
            step();
            for (int p = 0; p < NRD; p++) begin
                n_checks++;
                if (rd_data[p*XLEN +: XLEN] !== e_data[p] || rd_busy[p] !== e_busy[p]) begin
                    n_fail++;
                    $display("FAIL random c%0d p%0d: got data=%h busy=%b, want %h/%b", c, p,
                             rd_data[p*XLEN +: XLEN], rd_busy[p], e_data[p], e_busy[p]);
                end
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_bypass();
        test_conflict();
        test_hold();
        test_scoreboard();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
